timer_compare_unit: RTL and testbench
=====================================

Name: timer_compare_unit

Overview:
Parametrised timer with a built-in programmable comparator. It generalises the fixed "count > 200" check.
- Counts enabled ticks through a prescaler.
- Compares the count against a loadable threshold using a selectable relation (GT/GE/EQ/LT).
- Produces a registered level flag, a one-cycle hit pulse, and optional auto-reload.
- Feeds the traffic/FSM controllers as their timeout source (t0).

Parameters:
WIDTH, 8, counter and threshold width in bits.
THRESH_RST, 200, threshold register value after reset.
PRESCALE, 1, enabled clock cycles per count tick (>=1).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable; the prescaler and counter advance only while high.
clear  input  1  synchronous clear of counter and prescaler.
thr_load  input  1  load thr_in into the threshold register.
thr_in  input  WIDTH  new threshold value.
mode  input  2  compare relation: 00 GT, 01 GE, 10 EQ, 11 LT.
auto_reload  input  1  when high, the counter restarts at 0 on the tick after a match.
count  output  WIDTH  current counter value.
t0  output  1  registered compare result.
t0_pulse  output  1  one-cycle pulse on a 0->1 transition of the compare result.
sat  output  1  counter is held at all-ones.
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 HIT, 11 SAT.

Behaviour:
- Reset (async, rst=1): count=0, prescaler=0, thr=THRESH_RST, t0=0, t0_pulse=0, sat=0, state=IDLE. Releasing reset mid-operation simply restarts from these values.
- tick = en && (pre_cnt == PRESCALE-1). pre_cnt increments while en is high and wraps to 0 on tick. pre_cnt holds while en=0.
- match = combinational comparison of the current count against the current thr, using mode. Comparison is unsigned, at full WIDTH.
- Counter update priority, per clock edge:
  1. clear: count<=0, pre_cnt<=0.
  2. tick && auto_reload && match: count<=0.
  3. tick && count==all-ones: count holds (saturates, never wraps).
  4. tick: count<=count+1.
  5. otherwise: count holds.
- sat: registered, high when count==all-ones and auto_reload=0. Cleared by clear or by a reload.
- t0: registered, t0<=match. It lags count by one cycle.
- t0_pulse: registered, t0_pulse<=match && !t0. It is high for exactly one cycle per rising match.
- thr_load: thr<=thr_in. The new value affects match from the following cycle. clear and thr_load in the same cycle both take effect.
- mode change: affects match combinationally. t0 follows one cycle later.
- FSM, with next state evaluated in this order:
  - IDLE: en=1 -> RUN.
  - RUN: clear -> IDLE; match -> HIT; count==all-ones && !auto_reload -> SAT; en=0 -> IDLE.
  - HIT: clear -> IDLE; !match -> RUN.
  - SAT: clear -> IDLE (only exit). match does not leave SAT.
- Edge cases:
  - LT with thr=0 never matches. GE with thr=0 matches immediately (t0=1 one cycle after en).
  - GT with thr=all-ones never matches; the counter reaches SAT.
  - EQ with auto_reload gives a period of (thr+1)*PRESCALE cycles.
  - en dropping mid-prescale freezes pre_cnt; no partial tick is lost or added.

Decomposition:
- Shared package timer_pkg holds:
  - cmp_mode_e enum: CMP_GT, CMP_GE, CMP_EQ, CMP_LT.
  - tmr_state_e enum: IDLE, RUN, HIT, SAT.
- One sub-module: timer_prescaler (PRESCALE parameter; inputs clk, rst, en, clear; output tick). When PRESCALE=1, tick=en.

Test Plan:
1. Defaults (WIDTH=8, thr=200, mode=GT, PRESCALE=1), en=1 from reset -> count=201 after 201 cycles; t0 and t0_pulse rise one cycle later; state=HIT; t0_pulse is high for exactly one cycle.
2. mode=EQ, thr=9, auto_reload=1 -> count cycles 0..9. t0_pulse fires every 10 cycles. t0 is high one cycle per period. sat never asserts.
3. mode=GT, thr=255, auto_reload=0 -> count stops at 255. sat=1 and state=SAT on the following cycle. t0 stays 0. clear -> count=0, state=IDLE.
4. PRESCALE=4, mode=GE, thr=3 -> count increments every 4 cycles. Toggle en low for 5 cycles mid-run: count and pre_cnt freeze, and the match arrives exactly 5 cycles late.
5. At count=50, drive thr_load with thr_in=40 in the same cycle as clear -> count=0 and thr=40; the GT match occurs at count=41.
6. Assert rst asynchronously mid-count (count=120, not on a clock edge) -> all outputs zero immediately; thr=200 after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the timer/compare block: compare relations and controller states.
package timer_pkg;

  typedef enum logic [1:0] {
    CMP_GT = 2'b00,
    CMP_GE = 2'b01,
    CMP_EQ = 2'b10,
    CMP_LT = 2'b11
  } cmp_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10,
    SAT  = 2'b11
  } tmr_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divides enabled cycles into count ticks; tick is combinational from the divider state.
// No backpressure: the divider simply freezes while en is low.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_direct
      logic unused_in;
      assign unused_in = clk ^ rst ^ clear;
      assign tick      = en;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_cnt;

      assign tick = en && (pre_cnt == LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pre_cnt <= '0;
        end else if (clear) begin
          pre_cnt <= '0;
        end else if (tick) begin
          pre_cnt <= '0;
        end else if (en) begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/timer_compare_unit.sv
// Prescaled saturating counter with programmable compare; t0/t0_pulse/sat/state lag count by one cycle.
// No backpressure: en gates counting, clear restarts it synchronously.
module timer_compare_unit
  import timer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int THRESH_RST = 200,
  parameter int PRESCALE   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             thr_load,
  input  logic [WIDTH-1:0] thr_in,
  input  logic [1:0]       mode,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             t0,
  output logic             t0_pulse,
  output logic             sat,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic             tick;
  logic             match;
  logic             at_top;
  logic [WIDTH-1:0] thr;
  tmr_state_e       state_q;
  tmr_state_e       state_d;

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clear(clear),
    .tick (tick)
  );

  assign at_top = (count == ONES);

  always_comb begin
    match = 1'b0;
    case (cmp_mode_e'(mode))
      CMP_GT:  match = (count >  thr);
      CMP_GE:  match = (count >= thr);
      CMP_EQ:  match = (count == thr);
      CMP_LT:  match = (count <  thr);
      default: match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && auto_reload && match) begin
      count <= '0;
    end else if (tick && !at_top) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr <= WIDTH'(THRESH_RST);
    end else if (thr_load) begin
      thr <= thr_in;
    end
  end

  // Flags are sampled from the current count, so they trail it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0       <= 1'b0;
      t0_pulse <= 1'b0;
      sat      <= 1'b0;
    end else begin
      t0       <= match;
      t0_pulse <= match && !t0;
      sat      <= !clear && at_top && !auto_reload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (clear)                        state_d = IDLE;
        else if (match)                   state_d = HIT;
        else if (at_top && !auto_reload)  state_d = SAT;
        else if (!en)                     state_d = IDLE;
      end
      HIT: begin
        if (clear)       state_d = IDLE;
        else if (!match) state_d = RUN;
      end
      SAT: begin
        if (clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_timer_compare_unit.sv
// Directed bench for timer_compare_unit: default and prescaled instances share stimulus.
module tb_timer_compare_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clear;
  logic       thr_load;
  logic [7:0] thr_in;
  logic [1:0] mode;
  logic       auto_reload;

  logic [7:0] count, count4;
  logic       t0, t0_4;
  logic       t0_pulse, t0_pulse4;
  logic       sat, sat4;
  logic [1:0] state, state4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_compare_unit #(.WIDTH(8), .THRESH_RST(200), .PRESCALE(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .thr_load(thr_load),
    .thr_in(thr_in), .mode(mode), .auto_reload(auto_reload),
    .count(count), .t0(t0), .t0_pulse(t0_pulse), .sat(sat), .state(state)
  );

  timer_compare_unit #(.WIDTH(8), .THRESH_RST(200), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .thr_load(thr_load),
    .thr_in(thr_in), .mode(mode), .auto_reload(auto_reload),
    .count(count4), .t0(t0_4), .t0_pulse(t0_pulse4), .sat(sat4), .state(state4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; thr_load = 1'b0;
    thr_in = 8'd0; mode = 2'b00; auto_reload = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_t0", t0, 0);
    chk("rst_pulse", t0_pulse, 0);
    chk("rst_sat", sat, 0);
    chk("rst_state", state, 0);

    // Defaults: GT 200, counting from reset.
    #1; rst = 1'b0; en = 1'b1;
    step(201);
    chk("gt_count201", count, 201);
    chk("gt_t0_lag", t0, 0);
    chk("gt_state_run", state, 1);
    step(1);
    chk("gt_t0_rise", t0, 1);
    chk("gt_pulse_rise", t0_pulse, 1);
    chk("gt_state_hit", state, 2);
    step(1);
    chk("gt_pulse_once", t0_pulse, 0);
    chk("gt_t0_hold", t0, 1);

    // EQ 9 with auto-reload: period of 10.
    mode = 2'b10; thr_load = 1'b1; thr_in = 8'd9; auto_reload = 1'b1; clear = 1'b1;
    step(1);
    chk("eq_clear_count", count, 0);
    chk("eq_clear_state", state, 0);
    thr_load = 1'b0; clear = 1'b0;
    step(9);
    chk("eq_count9", count, 9);
    chk("eq_t0_pre", t0, 0);
    step(1);
    chk("eq_wrap", count, 0);
    chk("eq_t0", t0, 1);
    chk("eq_pulse", t0_pulse, 1);
    chk("eq_state_hit", state, 2);
    step(1);
    chk("eq_count1", count, 1);
    chk("eq_t0_fall", t0, 0);
    chk("eq_pulse_fall", t0_pulse, 0);
    step(9);
    chk("eq_pulse2", t0_pulse, 1);
    chk("eq_no_sat", sat, 0);

    // GT 255 never matches: saturation.
    mode = 2'b00; thr_load = 1'b1; thr_in = 8'd255; auto_reload = 1'b0; clear = 1'b1;
    step(1);
    thr_load = 1'b0; clear = 1'b0;
    step(255);
    chk("sat_count255", count, 255);
    chk("sat_not_yet", sat, 0);
    step(1);
    chk("sat_hold", count, 255);
    chk("sat_flag", sat, 1);
    chk("sat_state", state, 3);
    chk("sat_t0", t0, 0);
    clear = 1'b1;
    step(1);
    chk("sat_clr_count", count, 0);
    chk("sat_clr_state", state, 0);
    chk("sat_clr_flag", sat, 0);
    clear = 1'b0;

    // Threshold load together with clear.
    step(50);
    chk("ld_count50", count, 50);
    clear = 1'b1; thr_load = 1'b1; thr_in = 8'd40;
    step(1);
    chk("ld_clr_count", count, 0);
    clear = 1'b0; thr_load = 1'b0;
    step(41);
    chk("ld_count41", count, 41);
    chk("ld_t0_pre", t0, 0);
    step(1);
    chk("ld_t0", t0, 1);
    chk("ld_pulse", t0_pulse, 1);

    // Asynchronous reset mid-count, then default threshold returns.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(120);
    chk("ar_count120", count, 120);
    chk("ar_t0_pre", t0, 1);
    #3; rst = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_t0", t0, 0);
    chk("ar_pulse", t0_pulse, 0);
    chk("ar_state", state, 0);
    #2; rst = 1'b0;
    step(201);
    chk("ar_thr_t0_pre", t0, 0);
    step(1);
    chk("ar_thr_t0", t0, 1);

    // Prescale 4, GE 3, with a 5-cycle enable gap.
    rst = 1'b1; en = 1'b0;
    #2; rst = 1'b0;
    chk("p4_rst_count", count4, 0);
    mode = 2'b01; thr_load = 1'b1; thr_in = 8'd3;
    step(1);
    thr_load = 1'b0; en = 1'b1;
    step(3);
    chk("p4_count_pre", count4, 0);
    step(1);
    chk("p4_count1", count4, 1);
    step(2);
    en = 1'b0;
    step(5);
    chk("p4_frozen", count4, 1);
    chk("p4_state_idle", state4, 0);
    en = 1'b1;
    step(2);
    chk("p4_count2", count4, 2);
    step(4);
    chk("p4_count3", count4, 3);
    chk("p4_t0_pre", t0_4, 0);
    step(1);
    chk("p4_t0", t0_4, 1);
    chk("p4_pulse", t0_pulse4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
